// File: rtl/led_trail_pwm.sv
//==============================================================================
// Module      : led_trail_pwm
// Description : Per-channel brightness with load/decay, rendered as
//               period-latched PWM to form a fading LED trail.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module led_trail_pwm #(
    parameter int N_LEDS     = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 480000,
    parameter int DECAY_STEP = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [N_LEDS-1:0]            pattern,
    input  logic                         pattern_valid,
    input  logic [PWM_BITS-1:0]          max_level,
    output logic [N_LEDS-1:0]            led_out,
    output logic [N_LEDS*PWM_BITS-1:0]   level,
    output logic                         busy
);

    localparam int                   PS_W       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PS_W-1:0]      C_PS_LAST  = PS_W'(DECAY_DIV - 1);
    // PERIOD-1 = 2^PWM_BITS-2, so all-ones brightness is never reached by the counter
    localparam logic [PWM_BITS-1:0]  C_PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0]  C_STEP     = PWM_BITS'(DECAY_STEP);

    logic [PS_W-1:0]            ps_q, ps_d;
    logic [PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;
    logic                       busy_q;
    logic                       w_decay_tick;
    logic                       w_wrap;
    logic [N_LEDS*PWM_BITS-1:0] w_level_next;

    always_comb begin
        w_decay_tick = enable && (ps_q == C_PS_LAST);
        w_wrap       = enable && (pwm_cnt_q == C_PWM_LAST);
        ps_d         = (!enable || w_decay_tick) ? '0 : ps_q + PS_W'(1);
        pwm_cnt_d    = (!enable || w_wrap) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_q      <= '0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= |w_level_next;
        end
    end

    generate
        for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
            logic [PWM_BITS-1:0] lvl_q, lvl_d;
            logic [PWM_BITS-1:0] shadow_q, shadow_d;
            logic                led_q, led_d;

            // A load on the same edge as a decay tick takes priority
            always_comb begin
                lvl_d = lvl_q;
                if (pattern_valid && pattern[i]) begin
                    lvl_d = max_level;
                end else if (w_decay_tick) begin
                    lvl_d = (lvl_q > C_STEP) ? (lvl_q - C_STEP) : '0;
                end
                shadow_d = w_wrap ? lvl_q : shadow_q;
                led_d    = enable && (pwm_cnt_q < shadow_q);
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lvl_q    <= '0;
                    shadow_q <= '0;
                    led_q    <= 1'b0;
                end else begin
                    lvl_q    <= lvl_d;
                    shadow_q <= shadow_d;
                    led_q    <= led_d;
                end
            end

            assign level[i*PWM_BITS +: PWM_BITS]        = lvl_q;
            assign w_level_next[i*PWM_BITS +: PWM_BITS] = lvl_d;
            assign led_out[i]                           = led_q;
        end
    endgenerate

    assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
//==============================================================================
// Module      : tb_led_trail_pwm
// Description : Self-checking bench for led_trail_pwm (fast and slow decay).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_led_trail_pwm;

    localparam int NL    = 8;
    localparam int DIV_F = 10;
    localparam int DIV_S = 100000;
    localparam int STEP  = 64;
    localparam int PER   = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        pattern_valid;
    logic [7:0]  pattern;
    logic [7:0]  max_level;
    logic [7:0]  led_f, led_s;
    logic [63:0] lvl_f, lvl_s;
    logic        busy_f, busy_s;

    always #5 clk = ~clk;

    led_trail_pwm #(.N_LEDS(NL), .PWM_BITS(8), .DECAY_DIV(DIV_F), .DECAY_STEP(STEP)) dut_f (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern(pattern),
        .pattern_valid(pattern_valid), .max_level(max_level),
        .led_out(led_f), .level(lvl_f), .busy(busy_f));

    led_trail_pwm #(.N_LEDS(NL), .PWM_BITS(8), .DECAY_DIV(DIV_S), .DECAY_STEP(STEP)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern(pattern),
        .pattern_valid(pattern_valid), .max_level(max_level),
        .led_out(led_s), .level(lvl_s), .busy(busy_s));

    // Reference: time is the count of consecutive enabled cycles; decay ticks
    // and PWM period boundaries fall out of that count with modulo arithmetic.
    typedef struct packed {
        logic [7:0][7:0] lvl;
        logic [7:0][7:0] shd;
        logic [7:0]      led;
        logic            busy;
    } mstate_t;

    mstate_t m_f, m_s;
    int      m_cnt;
    int      n_checks = 0;
    int      n_errors = 0;

    function automatic mstate_t step(input mstate_t s, input int cnt, input int div,
                                     input logic en, input logic pv,
                                     input logic [7:0] pat, input logic [7:0] mx);
        mstate_t n;
        int      ph;
        bit      tick, wrap;
        n    = s;
        ph   = cnt % PER;
        tick = en && ((cnt % div) == div - 1);
        wrap = en && (ph == PER - 1);
        for (int i = 0; i < NL; i++) begin
            if (pv && pat[i])
                n.lvl[i] = mx;
            else if (tick)
                n.lvl[i] = (int'(s.lvl[i]) > STEP) ? 8'(int'(s.lvl[i]) - STEP) : 8'd0;
            n.led[i] = en && (ph < int'(s.shd[i]));
            if (wrap)
                n.shd[i] = s.lvl[i];
        end
        n.busy = (n.lvl != '0);
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_f   <= '0;
            m_s   <= '0;
            m_cnt <= 0;
        end else begin
            m_f   <= step(m_f, m_cnt, DIV_F, enable, pattern_valid, pattern, max_level);
            m_s   <= step(m_s, m_cnt, DIV_S, enable, pattern_valid, pattern, max_level);
            m_cnt <= enable ? m_cnt + 1 : 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("led_f",  64'(led_f),  64'(m_f.led));
            check("lvl_f",  lvl_f,       m_f.lvl);
            check("busy_f", 64'(busy_f), 64'(m_f.busy));
            check("led_s",  64'(led_s),  64'(m_s.led));
            check("lvl_s",  lvl_s,       m_s.lvl);
            check("busy_s", 64'(busy_s), 64'(m_s.busy));
        end
    end

    // Reset is dropped between clock edges so its effect must be asynchronous
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n       = 1'b0;
        pattern_valid = 1'b0;
        #1;
        check("rst_led_f",  64'(led_f),  64'd0);
        check("rst_lvl_f",  lvl_f,       64'd0);
        check("rst_busy_f", 64'(busy_f), 64'd0);
        check("rst_led_s",  64'(led_s),  64'd0);
        check("rst_lvl_s",  lvl_s,       64'd0);
        check("rst_busy_s", 64'(busy_s), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] pat, input logic [7:0] mx);
        pattern       = pat;
        max_level     = mx;
        pattern_valid = 1'b1;
        @(negedge clk);
        pattern_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  pat;
        logic [7:0]  mx;
        int          gap;
        logic [63:0] exp_f;
        logic [63:0] exp_s;
    } vec_t;

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[3];
        int   dexp[4];
        int   ones;
        int   k;
        int   prev;
        logic [63:0] frz_f, frz_s;

        tbl[0] = '{8'h01, 8'd200, 10, 64'h0000_0000_0000_00C8, 64'h0000_0000_0000_00C8};
        tbl[1] = '{8'h02, 8'd200, 10, 64'h0000_0000_0000_C888, 64'h0000_0000_0000_C8C8};
        tbl[2] = '{8'h04, 8'd200, 10, 64'h0000_0000_00C8_8848, 64'h0000_0000_00C8_C8C8};
        dexp   = '{191, 127, 63, 0};

        reset_n = 1'b1; enable = 1'b0; pattern_valid = 1'b0;
        pattern = 8'h00; max_level = 8'h00;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Idle: no load means a dark, non-busy output for several periods
        check("t1_rst_lvl",  lvl_f,       64'd0);
        check("t1_rst_led",  64'(led_f),  64'd0);
        check("t1_rst_busy", 64'(busy_f), 64'd0);
        enable = 1'b1;
        ones = 0;
        repeat (3*PER) begin
            @(negedge clk);
            ones += $countones(led_f) + $countones(led_s) + int'(busy_f);
        end
        check("t1_dark", 64'(ones), 64'd0);

        // Single channel load and saturating decay
        load(8'h01, 8'd255);
        check("t2_load", 64'(lvl_f[7:0]), 64'd255);
        check("t2_busy", 64'(busy_f),     64'd1);
        prev = 255;
        for (int j = 0; j < 4; j++) begin
            k = 0;
            while (int'(lvl_f[7:0]) == prev && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("t2_decay", 64'(lvl_f[7:0]), 64'(dexp[j]));
            if (j > 0) check("t2_tick_gap", 64'(k), 64'd10);
            check("t2_busy_track", 64'(busy_f), 64'(dexp[j] != 0));
            prev = dexp[j];
        end

        // Chaser sequence: later loads override while earlier channels decay
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load(tbl[i].pat, tbl[i].mx);
            check("t4_chaser_f", lvl_f, tbl[i].exp_f);
            check("t4_chaser_s", lvl_s, tbl[i].exp_s);
            repeat (tbl[i].gap - 1) @(negedge clk);
        end

        // Load coinciding with a decay tick
        do_reset();
        k = 0;
        while ((m_cnt % DIV_F) != 3 && k < 30) begin @(negedge clk); k++; end
        load(8'h10, 8'd200);
        load(8'h08, 8'd100);
        k = 0;
        while ((m_cnt % DIV_F) != DIV_F - 1 && k < 30) begin @(negedge clk); k++; end
        check("t5_align", 64'(m_cnt % DIV_F), 64'(DIV_F - 1));
        load(8'h08, 8'd100);
        check("t5_ch3_load_wins", 64'(lvl_f[31:24]), 64'd100);
        check("t5_ch4_decayed",   64'(lvl_f[39:32]), 64'd136);

        // Duty cycle and period-latched update on the slow instance
        do_reset();
        load(8'h80, 8'd64);
        repeat (300) @(negedge clk);
        ones = 0;
        repeat (PER) begin @(negedge clk); ones += int'(led_s[7]); end
        check("t3_duty64", 64'(ones), 64'd64);
        k = 0;
        while ((m_cnt % PER) != 100 && k < 300) begin @(negedge clk); k++; end
        load(8'h80, 8'd255);
        ones = int'(led_s[7]);
        repeat (154) begin @(negedge clk); ones += int'(led_s[7]); end
        check("t3_midperiod_unchanged", 64'(ones), 64'd0);
        ones = 0;
        repeat (PER) begin @(negedge clk); ones += int'(led_s[7]); end
        check("t3_full_on", 64'(ones), 64'd255);

        // Enable low freezes levels and darkens outputs
        load(8'hFF, 8'd255);
        enable = 1'b0;
        frz_f  = m_f.lvl;
        frz_s  = m_s.lvl;
        repeat (50) begin
            @(negedge clk);
            check("t6_dark", 64'({led_f, led_s}), 64'd0);
            check("t6_frozen_f", lvl_f, frz_f);
            check("t6_frozen_s", lvl_s, frz_s);
        end
        enable = 1'b1;
        repeat (600) @(negedge clk);
        do_reset();

        // Randomised traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            enable        = ($urandom_range(0, 19) != 0);
            pattern_valid = ($urandom_range(0, 3) == 0);
            pattern       = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       max_level = 8'hFF;
                1:       max_level = 8'h00;
                default: max_level = 8'($urandom);
            endcase
            if (c == 1500) do_reset();
        end
        pattern_valid = 1'b0;
        enable        = 1'b1;
        repeat (20) @(negedge clk);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
